// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue: default sizing, the queue entry
// layout and the round-robin pointer encoding.
package wb_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;

  // One queued register-file write, at the default widths.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  // Round-robin pointer encoding for the contested room==1 case.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding lookup for one read port: scans the occupied queue entries from
// oldest to youngest so that the youngest matching entry supplies the data.
module wbq_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic [AW-1:0]            ent_addr_i [DEPTH],
  input  logic [DW-1:0]            ent_data_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Priority search: a later (younger) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if ((i < int'(count_i)) && (ent_addr_i[idx] == rd_addr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU (A) and load-unit (B) results into one in-order
// register-file write port, one write per cycle, with optional forwarding of
// queued results to two read addresses. Define WBQ_FORWARD_EN to build the
// forwarding lookup; otherwise the fwd_* outputs are tied to zero.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [AW-1:0]          a_addr,
  input  logic [DW-1:0]          a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [AW-1:0]          b_addr,
  input  logic [DW-1:0]          b_data,
  output logic                   b_ready,
  output logic                   wb_we,
  output logic [AW-1:0]          wb_addr,
  output logic [DW-1:0]          wb_data,
  input  logic [AW-1:0]          rd_addr1,
  input  logic [AW-1:0]          rd_addr2,
  output logic                   fwd_hit1,
  output logic [DW-1:0]          fwd_data1,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Same field order as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;

  logic [CW-1:0] room;
  logic          contested;
  logic          push_a, push_b, pop;
  logic [1:0]    n_push;
  logic [PW-1:0] wr_b;

  // Admission: room is taken from start-of-cycle occupancy, so a same-cycle
  // pop never frees a slot; with one slot left a contest goes to the rr pointer.
  always_comb begin
    room      = CW'(DEPTH) - count_q;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    contested = 1'b0;
    if (!rst) begin
      if (room >= CW'(2)) begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end else if (room == CW'(1)) begin
        if (a_valid && b_valid) begin
          contested = 1'b1;
          a_ready   = (rr_q == RR_A);
          b_ready   = (rr_q == RR_B);
        end else begin
          a_ready = a_valid;
          b_ready = b_valid;
        end
      end
    end
  end

  // Next-state for pointers, occupancy and arbitration; A lands before B.
  always_comb begin
    push_a  = a_valid && a_ready;
    push_b  = b_valid && b_ready;
    pop     = (count_q != '0);
    n_push  = {1'b0, push_a} + {1'b0, push_b};
    wr_b    = wr_q + PW'(push_a);
    wr_d    = wr_q + PW'(n_push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + CW'(n_push) - CW'(pop);
    rr_d    = contested ? ~rr_q : rr_q;
  end

  // Control state; async reset drops every queued entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      rr_q    <= RR_A;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  // Entry storage; contents are don't-care once the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_a) mem_q[wr_q] <= '{addr: a_addr, data: a_data};
    if (push_b) mem_q[wr_b] <= '{addr: b_addr, data: b_data};
  end

  // Head of queue drives the register-file port every non-empty cycle.
  always_comb begin
    wb_we   = pop;
    wb_addr = pop ? mem_q[rd_q].addr : '0;
    wb_data = pop ? mem_q[rd_q].data : '0;
    count   = count_q;
  end

`ifdef WBQ_FORWARD_EN
  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];

  // Split entries into field arrays for the per-port lookups.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = mem_q[i].addr;
      ent_data[i] = mem_q[i].data;
    end
  end

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .ent_addr_i (ent_addr),
    .ent_data_i (ent_data),
    .head_i     (rd_q),
    .count_i    (count_q),
    .rd_addr_i  (rd_addr1),
    .hit_o      (fwd_hit1),
    .data_o     (fwd_data1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .ent_addr_i (ent_addr),
    .ent_data_i (ent_data),
    .head_i     (rd_q),
    .count_i    (count_q),
    .rd_addr_i  (rd_addr2),
    .hit_o      (fwd_hit2),
    .data_o     (fwd_data2)
  );
`else
  logic unused_rd;

  // Forwarding disabled: outputs tied off, read addresses ignored.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    unused_rd = ^{rd_addr1, rd_addr2};
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4, AW=5, DW=32): single/dual push,
// round-robin under full pressure, async reset mid-run, forwarding, wrap.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin scenario tables: A carries addr 1 / data A0+c, B addr 2 / B0+c.
  localparam logic [DW-1:0] S3_WD [7] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB3, 32'hA4};
  localparam logic [AW-1:0] S3_WA [7] = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1};
  localparam logic          S3_AR [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic          S3_BR [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0]    S3_CN [9] = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;

    // Reset state, with both producers requesting.
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_we", wb_we, 0);
    check("rst_aready", a_ready, 0);
    check("rst_bready", b_ready, 0);
    check("rst_fwdhit1", fwd_hit1, 0);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;

    // Single push.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("s1_aready", a_ready, 1);
    check("s1_we_c0", wb_we, 0);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("s1_we_c1", wb_we, 1);
    check("s1_addr_c1", wb_addr, 3);
    check("s1_data_c1", wb_data, 32'hDEAD_BEEF);
    check("s1_count_c1", count, 1);
    tick();
    @(negedge clk);
    check("s1_count_c2", count, 0);
    check("s1_we_c2", wb_we, 0);
    check("s1_addr_empty", wb_addr, 0);
    check("s1_data_empty", wb_data, 0);

    // Dual push on empty queue, forwarding between the two writes.
    tick();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h22;
    @(negedge clk);
    check("s2_aready", a_ready, 1);
    check("s2_bready", b_ready, 1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    rd_addr1 = 5'd5; rd_addr2 = 5'd7;
    @(negedge clk);
    check("s2_data_first", wb_data, 32'h11);
    check("s2_count", count, 2);
    check("s2_fwdhit1", fwd_hit1, FWD);
    check("s2_fwddata1", fwd_data1, FWD ? 32'h22 : 32'h0);
    check("s2_fwdhit2_miss", fwd_hit2, 0);
    tick();
    @(negedge clk);
    check("s2_data_second", wb_data, 32'h22);
    check("s2_we_second", wb_we, 1);
    check("s2_fwdhit1_head", fwd_hit1, FWD);
    check("s2_fwddata1_head", fwd_data1, FWD ? 32'h22 : 32'h0);
    tick();
    @(negedge clk);
    check("s2_count_end", count, 0);
    check("s2_fwdhit1_empty", fwd_hit1, 0);
    tick();

    // Both producers held valid: fill, then room==1 alternates A, B, A.
    for (int c = 0; c < 9; c++) begin
      a_valid = (c < 5); a_addr = 5'd1; a_data = 32'hA0 + 32'(c);
      b_valid = (c < 5); b_addr = 5'd2; b_data = 32'hB0 + 32'(c);
      @(negedge clk);
      check($sformatf("s3_count_c%0d", c), count, S3_CN[c]);
      if (c < 5) begin
        check($sformatf("s3_aready_c%0d", c), a_ready, S3_AR[c]);
        check($sformatf("s3_bready_c%0d", c), b_ready, S3_BR[c]);
      end
      if (c >= 1 && c <= 7) begin
        check($sformatf("s3_we_c%0d", c), wb_we, 1);
        check($sformatf("s3_data_c%0d", c), wb_data, S3_WD[c-1]);
        check($sformatf("s3_addr_c%0d", c), wb_addr, S3_WA[c-1]);
      end else begin
        check($sformatf("s3_we_c%0d", c), wb_we, 0);
      end
      tick();
    end

    // Async reset mid-operation with three entries queued.
    a_valid = 1'b1; b_valid = 1'b1; a_data = 32'h51; b_data = 32'h52;
    tick();
    a_data = 32'h53; b_data = 32'h54;
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    check("s4_count_pre", count, 3);
    #1;
    rst = 1'b1;
    #1;
    check("s4_count_rst", count, 0);
    check("s4_we_rst", wb_we, 0);
    check("s4_aready_rst", a_ready, 0);
    a_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("s4_we_after", wb_we, 0);
    check("s4_count_after", count, 0);
    tick();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    @(negedge clk);
    check("s4_we_after2", wb_we, 0);
    check("s4_aready_post", a_ready, 1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    check("s4_data_post", wb_data, 32'h99);
    check("s4_addr_post", wb_addr, 9);
    tick();

    // Ten back-to-back single pushes through the wrapping pointers.
    for (int i = 0; i <= 10; i++) begin
      a_valid = (i < 10); a_addr = AW'(i); a_data = 32'h100 + 32'(i);
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("s5_we_%0d", i), wb_we, 1);
        check($sformatf("s5_data_%0d", i), wb_data, 32'h100 + 32'(i - 1));
        check($sformatf("s5_addr_%0d", i), wb_addr, 64'(i - 1));
        check($sformatf("s5_count_%0d", i), count, 1);
      end
      tick();
    end
    @(negedge clk);
    check("s5_count_end", count, 0);
    check("s5_we_end", wb_we, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
